// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock FIFO: controller and storage array in one block. Provides
// full/empty, programmable almost-full/almost-empty thresholds, a fill count,
// a read-valid strobe and sticky overflow/underflow error flags.
//
// Optional feature: define SYNC_FIFO_FWFT_EN for first-word-fall-through
// reads. Without it, reads are registered: an accepted read at edge N
// updates rd_data_o at N and pulses rd_valid_o for one cycle.
//
// Ports:
//   clk_i              single clock, rising edge
//   rst_i              asynchronous, active-high reset
//   wr_en_i/wr_data_i  write request and data
//   wr_full_o          FIFO full (count == FIFO_DEPTH)
//   wr_almost_full_o   count >= AFULL_THRESH
//   rd_en_i            read request (pop in FWFT mode)
//   rd_data_o          read data
//   rd_valid_o         rd_data_o carries a newly popped / head word
//   rd_empty_o         FIFO empty
//   rd_almost_empty_o  count <= AEMPTY_THRESH
//   fill_count_o       entries currently held, 0..FIFO_DEPTH
//   clr_err_i          clears the sticky error flags
//   overflow_o         sticky: write attempted while full
//   underflow_o        sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 128,
    parameter int ADDR_WIDTH    = $clog2(FIFO_DEPTH),
    parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_full_o,
    output logic                  wr_almost_full_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_empty_o,
    output logic                  rd_almost_empty_o,
    output logic [ADDR_WIDTH:0]   fill_count_o,
    input  logic                  clr_err_i,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDR_WIDTH:0] FULL_C   = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_load;
    logic                  wr_err;
    logic                  rd_err;
    logic                  valid_next;

    // Accept decisions use the registered flags from the start of the cycle.
    assign wr_acc = wr_en_i & ~wr_full_o;
    assign wr_err = wr_en_i & wr_full_o;

`ifdef SYNC_FIFO_FWFT_EN
    // The output register holds the head word; count includes it, so the
    // array occupancy is count minus the output register's valid bit.
    logic [ADDR_WIDTH:0] mem_count;

    assign mem_count  = count - {{ADDR_WIDTH{1'b0}}, rd_valid_o};
    assign rd_acc     = rd_en_i & rd_valid_o;
    assign rd_err     = rd_en_i & ~rd_valid_o;
    // Refill the output register whenever it is empty or being popped.
    assign rd_load    = (mem_count != '0) & (~rd_valid_o | rd_acc);
    assign valid_next = rd_load | (rd_valid_o & ~rd_acc);
`else
    assign rd_acc     = rd_en_i & ~rd_empty_o;
    assign rd_err     = rd_en_i & rd_empty_o;
    assign rd_load    = rd_acc;
    assign valid_next = rd_acc;
`endif

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    assign fill_count_o = count;

    // NOTE: the storage array sits in its own clocked block with no reset so
    // it maps onto RAM; its contents are meaningless until written anyway.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            rd_data_o         <= '0;
            rd_valid_o        <= 1'b0;
            rd_empty_o        <= 1'b1;
            rd_almost_empty_o <= 1'b1;
            wr_full_o         <= 1'b0;
            wr_almost_full_o  <= 1'b0;
            overflow_o        <= 1'b0;
            underflow_o       <= 1'b0;
        end else begin
            count <= count_next;

            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_load) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_data_o <= mem[rd_ptr];
            end
            rd_valid_o <= valid_next;

`ifdef SYNC_FIFO_FWFT_EN
            rd_empty_o <= ~valid_next;
`else
            rd_empty_o <= (count_next == '0);
`endif
            wr_full_o         <= (count_next == FULL_C);
            wr_almost_full_o  <= (count_next >= AFULL_C);
            rd_almost_empty_o <= (count_next <= AEMPTY_C);

            // A new error event wins over a simultaneous clear.
            overflow_o  <= wr_err | (overflow_o  & ~clr_err_i);
            underflow_o <= rd_err | (underflow_o & ~clr_err_i);
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
//
// Self-checking bench for sync_fifo_ctrl in its default (registered-read)
// build. A queue-based model tracks FIFO contents, read data, error flags and
// pointer positions; a negedge process compares every DUT output against it
// each cycle. Directed sequences add literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 128;
    localparam int AW    = $clog2(DEPTH);
    localparam int AFULL = DEPTH - 4;
    localparam int AEMPT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic          wr_full, wr_almost_full, rd_valid, rd_empty, rd_almost_empty;
    logic          overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [AW:0]   fill_count;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .wr_en_i           (wr_en),
        .wr_data_i         (wr_data),
        .wr_full_o         (wr_full),
        .wr_almost_full_o  (wr_almost_full),
        .rd_en_i           (rd_en),
        .rd_data_o         (rd_data),
        .rd_valid_o        (rd_valid),
        .rd_empty_o        (rd_empty),
        .rd_almost_empty_o (rd_almost_empty),
        .fill_count_o      (fill_count),
        .clr_err_i         (clr_err),
        .overflow_o        (overflow),
        .underflow_o       (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_data;
    logic          m_valid, m_ovf, m_unf;
    int            m_wp, m_rp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_wp    = 0;
            m_rp    = 0;
        end else begin
            bit full, empty;
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            m_valid = 1'b0;
            if (rd_en && !empty) begin
                m_data  = q.pop_front();
                m_valid = 1'b1;
                m_rp    = (m_rp + 1) % DEPTH;
            end
            if (wr_en && !full) begin
                q.push_back(wr_data);
                m_wp = (m_wp + 1) % DEPTH;
            end
            m_ovf = (wr_en && full)  || (m_ovf && !clr_err);
            m_unf = (rd_en && empty) || (m_unf && !clr_err);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_data",      32'(rd_data),         32'(m_data));
            check("rd_valid",     32'(rd_valid),        32'(m_valid));
            check("fill_count",   32'(fill_count),      32'(q.size()));
            check("rd_empty",     32'(rd_empty),        32'(q.size() == 0));
            check("wr_full",      32'(wr_full),         32'(q.size() == DEPTH));
            check("almost_full",  32'(wr_almost_full),  32'(q.size() >= AFULL));
            check("almost_empty", 32'(rd_almost_empty), 32'(q.size() <= AEMPT));
            check("overflow",     32'(overflow),        32'(m_ovf));
            check("underflow",    32'(underflow),       32'(m_unf));
            check("wr_ptr",       32'(dut.wr_ptr),      32'(m_wp));
            check("rd_ptr",       32'(dut.rd_ptr),      32'(m_rp));
        end
    end

    // Apply one cycle of stimulus; returns at the following negedge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"}, 32'(fill_count),      32'd0);
        check({tag, "_empty"}, 32'(rd_empty),        32'd1);
        check({tag, "_aempt"}, 32'(rd_almost_empty), 32'd1);
        check({tag, "_full"},  32'(wr_full),         32'd0);
        check({tag, "_afull"}, 32'(wr_almost_full),  32'd0);
        check({tag, "_valid"}, 32'(rd_valid),        32'd0);
        check({tag, "_data"},  32'(rd_data),         32'd0);
        check({tag, "_ovf"},   32'(overflow),        32'd0);
        check({tag, "_unf"},   32'(underflow),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic write 1..4 then read 4
        for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        check("basic_count4", 32'(fill_count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("basic_rd_valid", 32'(rd_valid), 32'd1);
            check("basic_rd_data",  32'(rd_data),  32'(i));
        end
        step(1'b0, '0, 1'b0, 1'b0);
        check("basic_valid_drop", 32'(rd_valid),   32'd0);
        check("basic_hold_data",  32'(rd_data),    32'h0004);
        check("basic_count0",     32'(fill_count), 32'd0);
        check("basic_empty",      32'(rd_empty),   32'd1);

        // Fill to full, watching the almost-full threshold
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
            if (i + 1 == AFULL - 1) check("afull_below", 32'(wr_almost_full), 32'd0);
            if (i + 1 == AFULL)     check("afull_at",    32'(wr_almost_full), 32'd1);
        end
        check("fill_full",  32'(wr_full),    32'd1);
        check("fill_count", 32'(fill_count), 32'd128);
        step(1'b1, 16'hFFFF, 1'b0, 1'b0);
        check("ovf_set",   32'(overflow),   32'd1);
        check("ovf_count", 32'(fill_count), 32'd128);
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr",   32'(overflow),   32'd0);

        // Full FIFO, simultaneous write and read
        step(1'b1, 16'hDEAD, 1'b1, 1'b0);
        check("fullrw_data",  32'(rd_data),    32'h1000);
        check("fullrw_ovf",   32'(overflow),   32'd1);
        check("fullrw_count", 32'(fill_count), 32'd127);
        check("fullrw_full",  32'(wr_full),    32'd0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Drain; the dropped 0xDEAD must never appear
        for (int i = 1; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("drain_last",  32'(rd_data),    32'h107F);
        check("drain_count", 32'(fill_count), 32'd0);

        // Empty FIFO, simultaneous write and read
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        check("emptyrw_unf",   32'(underflow),  32'd1);
        check("emptyrw_count", 32'(fill_count), 32'd1);
        check("emptyrw_valid", 32'(rd_valid),   32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("emptyrw_data",  32'(rd_data),    32'hBEEF);
        check("emptyrw_clr",   32'(underflow),  32'd0);
        // Clear coinciding with a new underflow: set wins
        step(1'b0, '0, 1'b1, 1'b1);
        check("setwins_unf",   32'(underflow),  32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("unf_clr",       32'(underflow),  32'd0);

        // Pointer wrap with count held at 5
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
        for (int i = 5; i < 305; i++) step(1'b1, 16'(16'h2000 + i), 1'b1, 1'b0);
        check("wrap_count", 32'(fill_count), 32'd5);
        check("wrap_data",  32'(rd_data),    32'(16'h2000 + 299));
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("wrap_tail",  32'(rd_data),    32'(16'h2000 + 304));

        // Asynchronous reset mid-burst at count 37
        for (int i = 0; i < 37; i++) step(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(fill_count), 32'd37);
        wr_en   = 1'b1;
        wr_data = 16'h3FFF;
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b0;
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_rst_data",  32'(rd_data),  32'h1234);
        check("post_rst_valid", 32'(rd_valid), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
